// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: FSM states,
// opcode/funct values and the datapath select codes.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_LUI = 3'b101;

  localparam logic [1:0] PC_ALU = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  localparam logic [1:0] SRCB_BUSB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Opcodes the controller knows how to sequence; R-type funct is checked separately.
  function automatic logic op_known(input logic [5:0] o);
    case (o)
      OP_RTYPE, OP_J, OP_BEQ, OP_ORI, OP_LUI, OP_LW, OP_SW: op_known = 1'b1;
      default:                                              op_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// R-type funct decoder: maps funct to the ALU operation and flags unsupported codes.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] aluctl,
  output logic       legal
);

  always_comb begin
    aluctl = ALU_ADD;
    legal  = 1'b1;
    case (funct)
      F_ADDU:  aluctl = ALU_ADD;
      F_SUBU:  aluctl = ALU_SUB;
      F_AND:   aluctl = ALU_AND;
      F_OR:    aluctl = ALU_OR;
      F_SLT:   aluctl = ALU_SLT;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM (IF/ID/EX/MEM/WB) for the MIPS-subset CPU, with a
// watchdog on the unified memory request.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       irwr,
  output logic       pcwr,
  output logic [1:0] pcsrc,
  output logic       regwr,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       extop,
  output logic [2:0] aluctl,
  output logic [2:0] state,
  output logic       ill_instr,
  output logic       timeout_err
);

  // Memory handshake: mem_req is held high until a cycle with mem_ack=1, which
  // completes the transfer in that same cycle; if the watchdog expires first the
  // request is withdrawn for one cycle and the fetch restarts from IF.

  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               WDOG_EN = (TIMEOUT_CYCLES != 0);

  state_t           state_q, state_nx;
  logic [5:0]       op_q, funct_q;
  logic [CNT_W-1:0] cnt_q;
  logic             abort_q;
  logic             timeout_q;

  logic [5:0] dec_op, dec_funct;
  logic [2:0] dec_aluctl;
  logic       dec_legal;
  logic       instr_legal;
  logic       mem_busy;
  logic       expire;

  // In ID the IR fields are live on op/funct; afterwards use the latched copies.
  assign dec_op    = (state_q == S_ID) ? op    : op_q;
  assign dec_funct = (state_q == S_ID) ? funct : funct_q;

  mc_alu_dec u_alu_dec (
    .funct  (dec_funct),
    .aluctl (dec_aluctl),
    .legal  (dec_legal)
  );

  assign instr_legal = op_known(dec_op) && ((dec_op != OP_RTYPE) || dec_legal);
  assign mem_busy    = ((state_q == S_IF) && !abort_q) || (state_q == S_MEM);
  assign expire      = WDOG_EN && mem_busy && !mem_ack && (cnt_q == CNT_LIM);

  assign state       = state_q;
  assign timeout_err = timeout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IF;
      op_q      <= '0;
      funct_q   <= '0;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_nx;
      abort_q <= expire;
      if (expire) timeout_q <= 1'b1;
      if (state_q == S_ID) begin
        op_q    <= op;
        funct_q <= funct;
      end
      if (mem_busy && !mem_ack && !expire) cnt_q <= cnt_q + 1'b1;
      else                                 cnt_q <= '0;
    end
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IF: begin
        if (!abort_q && mem_ack) state_nx = S_ID;
      end
      S_ID: begin
        if (!instr_legal || (dec_op == OP_J)) state_nx = S_IF;
        else                                  state_nx = S_EX;
      end
      S_EX: begin
        case (op_q)
          OP_LW, OP_SW:              state_nx = S_MEM;
          OP_RTYPE, OP_ORI, OP_LUI:  state_nx = S_WB;
          default:                   state_nx = S_IF;
        endcase
      end
      S_MEM: begin
        if (mem_ack)     state_nx = (op_q == OP_LW) ? S_WB : S_IF;
        else if (expire) state_nx = S_IF;
      end
      default: state_nx = S_IF;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    irwr      = 1'b0;
    pcwr      = 1'b0;
    pcsrc     = PC_ALU;
    regwr     = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = SRCB_BUSB;
    extop     = 1'b0;
    aluctl    = ALU_ADD;
    ill_instr = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_IF: begin
          mem_req = !abort_q;
          alusrcb = SRCB_FOUR;
          if (!abort_q && mem_ack) begin
            irwr = 1'b1;
            pcwr = 1'b1;
          end
        end
        S_ID: begin
          alusrcb = SRCB_IMM_SH;
          extop   = 1'b1;
          if (!instr_legal) begin
            ill_instr = 1'b1;
          end else if (dec_op == OP_J) begin
            pcwr  = 1'b1;
            pcsrc = PC_JMP;
          end
        end
        S_EX: begin
          case (op_q)
            OP_RTYPE: begin
              alusrca = 1'b1;
              aluctl  = dec_aluctl;
            end
            OP_LW, OP_SW: begin
              alusrca = 1'b1;
              alusrcb = SRCB_IMM;
              extop   = 1'b1;
            end
            OP_ORI: begin
              alusrca = 1'b1;
              alusrcb = SRCB_IMM;
              aluctl  = ALU_OR;
            end
            OP_LUI: begin
              alusrcb = SRCB_IMM;
              aluctl  = ALU_LUI;
            end
            OP_BEQ: begin
              alusrca = 1'b1;
              aluctl  = ALU_SUB;
              pcwr    = zero;
              pcsrc   = PC_BR;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = (op_q == OP_SW);
        end
        S_WB: begin
          regwr    = 1'b1;
          regdst   = (op_q == OP_RTYPE);
          memtoreg = (op_q == OP_LW);
        end
        default: ;
      endcase
    end
  end

endmodule
